// File: rtl/ibex_fp_regfile_scoreboard.sv
// FP register file with integrated write scoreboard for the ibex FPU path.
// Three combinational read ports (rs1/rs2/rs3), two write ports (FPU and load
// writeback), and a per-register busy bit that tracks outstanding multi-cycle
// FPU ops so decode can stall on hazards.
// Optional feature macro: FP_RF_BYPASS_EN (same-cycle write-to-read forwarding
// and hazard masking on FPU writeback).
module ibex_fp_regfile_scoreboard #(
  parameter int unsigned          DataWidth   = 16,
  parameter int unsigned          NumRegs     = 32,
  parameter bit                   ZeroReg     = 1'b0,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  localparam int unsigned         AW          = $clog2(NumRegs)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AW-1:0]        raddr_a_i,
  input  logic [AW-1:0]        raddr_b_i,
  input  logic [AW-1:0]        raddr_c_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic [DataWidth-1:0] rdata_c_o,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 hazard_c_o,
  input  logic                 issue_valid_i,
  input  logic [AW-1:0]        issue_rd_i,
  output logic                 issue_ready_o,
  input  logic                 wb_fpu_we_i,
  input  logic [AW-1:0]        wb_fpu_addr_i,
  input  logic [DataWidth-1:0] wb_fpu_data_i,
  input  logic                 wb_ld_we_i,
  input  logic [AW-1:0]        wb_ld_addr_i,
  input  logic [DataWidth-1:0] wb_ld_data_i,
  output logic [NumRegs-1:0]   busy_o,
  output logic                 err_o
);

  logic [DataWidth-1:0] regs_q [NumRegs];
  logic [NumRegs-1:0]   busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 fpu_we, ld_we, issue_acc;

  logic [AW-1:0]        raddr [3];
  logic [DataWidth-1:0] rdata [3];
  logic [2:0]           hazard;

  // Effective write enables: writes to a hardwired zero register are dropped.
  always_comb begin
    fpu_we = wb_fpu_we_i && !(ZeroReg && (wb_fpu_addr_i == '0));
    ld_we  = wb_ld_we_i && !(ZeroReg && (wb_ld_addr_i == '0));
  end

  // A busy rd is still issuable if its pending op retires this very cycle.
  assign issue_ready_o = !busy_q[issue_rd_i] ||
                         (wb_fpu_we_i && (wb_fpu_addr_i == issue_rd_i));
  assign issue_acc     = issue_valid_i && issue_ready_o &&
                         !(ZeroReg && (issue_rd_i == '0));

  // Scoreboard next state: FPU writeback retires, a same-cycle issue re-arms.
  always_comb begin
    busy_d = busy_q;
    if (fpu_we) begin
      busy_d[wb_fpu_addr_i] = 1'b0;
    end
    if (issue_acc) begin
      busy_d[issue_rd_i] = 1'b1;
    end
  end

  // Protocol errors: dual write collision, load WAW on busy reg, spurious FPU wb.
  always_comb begin
    err_d = (fpu_we && ld_we && (wb_fpu_addr_i == wb_ld_addr_i)) ||
            (ld_we && busy_q[wb_ld_addr_i]) ||
            (fpu_we && !busy_q[wb_fpu_addr_i]);
  end

  // Scoreboard and error pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // Register storage; the FPU write is issued last so it wins on a collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= WordZeroVal;
      end
    end else begin
      if (ld_we) begin
        regs_q[wb_ld_addr_i] <= wb_ld_data_i;
      end
      if (fpu_we) begin
        regs_q[wb_fpu_addr_i] <= wb_fpu_data_i;
      end
    end
  end

  assign raddr[0] = raddr_a_i;
  assign raddr[1] = raddr_b_i;
  assign raddr[2] = raddr_c_i;

  // Read ports: committed state, optional forwarding, zero-register override.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rdata[i]  = regs_q[raddr[i]];
      hazard[i] = busy_q[raddr[i]];
`ifdef FP_RF_BYPASS_EN
      if (fpu_we && (wb_fpu_addr_i == raddr[i])) begin
        rdata[i] = wb_fpu_data_i;
        // Retiring this cycle: no hazard unless a new op re-claims it now.
        if (!(issue_acc && (issue_rd_i == raddr[i]))) begin
          hazard[i] = 1'b0;
        end
      end else if (ld_we && (wb_ld_addr_i == raddr[i])) begin
        rdata[i] = wb_ld_data_i;
      end
`endif
      if (ZeroReg && (raddr[i] == '0)) begin
        rdata[i]  = WordZeroVal;
        hazard[i] = 1'b0;
      end
    end
  end

  assign rdata_a_o  = rdata[0];
  assign rdata_b_o  = rdata[1];
  assign rdata_c_o  = rdata[2];
  assign hazard_a_o = hazard[0];
  assign hazard_b_o = hazard[1];
  assign hazard_c_o = hazard[2];
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_ibex_fp_regfile_scoreboard.sv
// Self-checking bench for ibex_fp_regfile_scoreboard: directed literal checks
// followed by randomized traffic compared against a behavioural model.
module tb_ibex_fp_regfile_scoreboard;

  localparam int unsigned DW  = 16;
  localparam int unsigned NR  = 32;
  localparam int unsigned AW  = 5;
  localparam bit          ZR  = 1'b1;
  localparam logic [DW-1:0] WZV = 16'h3C00;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [AW-1:0] raddr_a, raddr_b, raddr_c;
  logic [DW-1:0] rdata_a, rdata_b, rdata_c;
  logic          hazard_a, hazard_b, hazard_c;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_ready;
  logic          wb_fpu_we;
  logic [AW-1:0] wb_fpu_addr;
  logic [DW-1:0] wb_fpu_data;
  logic          wb_ld_we;
  logic [AW-1:0] wb_ld_addr;
  logic [DW-1:0] wb_ld_data;
  logic [NR-1:0] busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [DW-1:0] mreg  [NR];
  bit            mbusy [NR];
  bit            merr;

  always #5 clk_i = ~clk_i;

  ibex_fp_regfile_scoreboard #(
    .DataWidth  (DW),
    .NumRegs    (NR),
    .ZeroReg    (ZR),
    .WordZeroVal(WZV)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .raddr_a_i    (raddr_a),
    .raddr_b_i    (raddr_b),
    .raddr_c_i    (raddr_c),
    .rdata_a_o    (rdata_a),
    .rdata_b_o    (rdata_b),
    .rdata_c_o    (rdata_c),
    .hazard_a_o   (hazard_a),
    .hazard_b_o   (hazard_b),
    .hazard_c_o   (hazard_c),
    .issue_valid_i(issue_valid),
    .issue_rd_i   (issue_rd),
    .issue_ready_o(issue_ready),
    .wb_fpu_we_i  (wb_fpu_we),
    .wb_fpu_addr_i(wb_fpu_addr),
    .wb_fpu_data_i(wb_fpu_data),
    .wb_ld_we_i   (wb_ld_we),
    .wb_ld_addr_i (wb_ld_addr),
    .wb_ld_data_i (wb_ld_data),
    .busy_o       (busy),
    .err_o        (err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0;
    wb_fpu_we = 1'b0; wb_fpu_addr = '0; wb_fpu_data = '0;
    wb_ld_we = 1'b0; wb_ld_addr = '0; wb_ld_data = '0;
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mreg[i]  = WZV;
      mbusy[i] = 1'b0;
    end
    merr = 1'b0;
  endtask

  function automatic bit is_zero(input logic [AW-1:0] a);
    return ZR && (a == '0);
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
    if (is_zero(a)) return WZV;
`ifdef FP_RF_BYPASS_EN
    if (wb_fpu_we && !is_zero(wb_fpu_addr) && wb_fpu_addr == a) return wb_fpu_data;
    if (wb_ld_we && !is_zero(wb_ld_addr) && wb_ld_addr == a) return wb_ld_data;
`endif
    return mreg[a];
  endfunction

  function automatic bit exp_ready();
    return !mbusy[issue_rd] || (wb_fpu_we && wb_fpu_addr == issue_rd);
  endfunction

  function automatic bit exp_hazard(input logic [AW-1:0] a);
    if (is_zero(a)) return 1'b0;
`ifdef FP_RF_BYPASS_EN
    if (wb_fpu_we && wb_fpu_addr == a &&
        !(issue_valid && exp_ready() && issue_rd == a)) return 1'b0;
`endif
    return mbusy[a];
  endfunction

  // Compare every DUT output against the model for the current cycle.
  task automatic compare_model();
    logic [NR-1:0] vb;
    for (int i = 0; i < NR; i++) vb[i] = mbusy[i];
    chk("rdata_a", 64'(rdata_a), 64'(exp_rdata(raddr_a)));
    chk("rdata_b", 64'(rdata_b), 64'(exp_rdata(raddr_b)));
    chk("rdata_c", 64'(rdata_c), 64'(exp_rdata(raddr_c)));
    chk("hazard_a", 64'(hazard_a), 64'(exp_hazard(raddr_a)));
    chk("hazard_b", 64'(hazard_b), 64'(exp_hazard(raddr_b)));
    chk("hazard_c", 64'(hazard_c), 64'(exp_hazard(raddr_c)));
    chk("issue_ready", 64'(issue_ready), 64'(exp_ready()));
    chk("busy_o", 64'(busy), 64'(vb));
    chk("err_o", 64'(err), 64'(merr));
  endtask

  // Apply the rules for one clock edge to the model, committing at the edge.
  task automatic model_clock();
    logic [DW-1:0] nreg [NR];
    bit            nbusy [NR];
    bit            nerr;
    bit            fe, le, acc;
    fe  = wb_fpu_we && !is_zero(wb_fpu_addr);
    le  = wb_ld_we && !is_zero(wb_ld_addr);
    acc = issue_valid && exp_ready() && !is_zero(issue_rd);
    nreg  = mreg;
    nbusy = mbusy;
    nerr  = 1'b0;
    if (fe && le && wb_fpu_addr == wb_ld_addr) nerr = 1'b1;
    if (le && mbusy[wb_ld_addr]) nerr = 1'b1;
    if (fe && !mbusy[wb_fpu_addr]) nerr = 1'b1;
    if (le) nreg[wb_ld_addr] = wb_ld_data;
    if (fe) begin
      nreg[wb_fpu_addr]  = wb_fpu_data;
      nbusy[wb_fpu_addr] = 1'b0;
    end
    if (acc) nbusy[issue_rd] = 1'b1;
    @(posedge clk_i);
    mreg  = nreg;
    mbusy = nbusy;
    merr  = nerr;
    #1;
  endtask

  initial begin
    idle();
    raddr_a = '0; raddr_b = '0; raddr_c = '0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset state.
    raddr_a = 5'd1; raddr_b = 5'd9; raddr_c = 5'd31;
    #1;
    chk("rst_rdata_a", 64'(rdata_a), 64'h3C00);
    chk("rst_rdata_b", 64'(rdata_b), 64'h3C00);
    chk("rst_rdata_c", 64'(rdata_c), 64'h3C00);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_ready", 64'(issue_ready), 64'h1);
    rst_ni = 1'b1;
    step();

    // Issue rd=5 then observe hazard, then retire with 4200.
    raddr_a = 5'd5;
    issue_valid = 1'b1; issue_rd = 5'd5;
    step();
    idle();
    #1;
    chk("haz_after_issue", 64'(hazard_a), 64'h1);
    wb_fpu_we = 1'b1; wb_fpu_addr = 5'd5; wb_fpu_data = 16'h4200;
    step();
    idle();
    #1;
    chk("haz_after_wb", 64'(hazard_a), 64'h0);
    chk("rdata_after_wb", 64'(rdata_a), 64'h4200);
    chk("err_good_wb", 64'(err), 64'h0);

    // Busy rd=5 re-issued in the same cycle as its writeback.
    issue_valid = 1'b1; issue_rd = 5'd5;
    step();
    wb_fpu_we = 1'b1; wb_fpu_addr = 5'd5; wb_fpu_data = 16'h1234;
    #1;
    chk("reissue_ready", 64'(issue_ready), 64'h1);
    step();
    idle();
    #1;
    chk("reissue_busy5", 64'(busy[5]), 64'h1);
    chk("reissue_data", 64'(rdata_a), 64'h1234);
    wb_fpu_we = 1'b1; wb_fpu_addr = 5'd5; wb_fpu_data = 16'h0;
    step();
    idle();

    // Dual write collision on reg 7.
    raddr_a = 5'd7;
    wb_fpu_we = 1'b1; wb_fpu_addr = 5'd7; wb_fpu_data = 16'h1111;
    wb_ld_we = 1'b1; wb_ld_addr = 5'd7; wb_ld_data = 16'h2222;
    step();
    idle();
    #1;
    chk("collide_data", 64'(rdata_a), 64'h1111);
    chk("collide_err", 64'(err), 64'h1);
    step();
    chk("collide_err_pulse", 64'(err), 64'h0);

    // Zero register: issue and load to 0 dropped.
    raddr_c = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd0;
    wb_ld_we = 1'b1; wb_ld_addr = 5'd0; wb_ld_data = 16'hFFFF;
    step();
    idle();
    #1;
    chk("zero_busy", 64'(busy), 64'h0);
    chk("zero_rdata", 64'(rdata_c), 64'h3C00);
    chk("zero_err", 64'(err), 64'h0);

    // Load to reg 3 read on port b in the same cycle.
    raddr_b = 5'd3;
    wb_ld_we = 1'b1; wb_ld_addr = 5'd3; wb_ld_data = 16'hABCD;
    #1;
`ifdef FP_RF_BYPASS_EN
    chk("bypass_rdata_b", 64'(rdata_b), 64'hABCD);
`else
    chk("nobypass_rdata_b", 64'(rdata_b), 64'h3C00);
`endif
    step();
    idle();
    #1;
    chk("ld_commit_b", 64'(rdata_b), 64'hABCD);

    // Reset mid-operation discards pending op; late writeback flags an error.
    issue_valid = 1'b1; issue_rd = 5'd2;
    step();
    idle();
    #1;
    chk("pre_rst_busy2", 64'(busy[2]), 64'h1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'h0);
    step();
    rst_ni = 1'b1;
    raddr_a = 5'd2;
    wb_fpu_we = 1'b1; wb_fpu_addr = 5'd2; wb_fpu_data = 16'h5555;
    step();
    idle();
    #1;
    chk("late_wb_err", 64'(err), 64'h1);
    chk("late_wb_data", 64'(rdata_a), 64'h5555);

    // Randomized traffic against the model from a fresh reset.
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      raddr_a     = AW'($urandom_range(0, 7));
      raddr_b     = AW'($urandom_range(0, 7));
      raddr_c     = AW'($urandom_range(0, 31));
      issue_valid = ($urandom_range(0, 1) == 0);
      issue_rd    = AW'($urandom_range(0, 7));
      wb_fpu_we   = ($urandom_range(0, 2) == 0);
      wb_fpu_addr = AW'($urandom_range(0, 7));
      wb_fpu_data = DW'($urandom);
      wb_ld_we    = ($urandom_range(0, 3) == 0);
      wb_ld_addr  = AW'($urandom_range(0, 7));
      wb_ld_data  = DW'($urandom);
      #1;
      compare_model();
      model_clock();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
